jk_bank_arbiter: RTL and testbench

//  Round-robin controller that lets NREQ requesters share one WIDTH-bit register bank built from JK flip-flop cells.

---
 rtl/jk_bank_arbiter.sv | 157 +++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one JK flip-flop register bank among NREQ requesters.
// Each granted op/arg is translated into per-bit J/K drive for one EXEC cycle.
module jk_bank_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       op,
    input  logic [WIDTH*NREQ-1:0]   arg,
    output logic [NREQ-1:0]         gnt,
    output logic                    ack,
    output logic                    busy,
    output logic [WIDTH-1:0]        q,
    output logic [WIDTH-1:0]        q_bar
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win_reg;
    logic [1:0]        lat_op;
    logic [WIDTH-1:0]  lat_arg;

    logic              found;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     cand;
    logic [WIDTH-1:0]  j;
    logic [WIDTH-1:0]  k;

    logic [1:0]        op_arr  [NREQ];
    logic [WIDTH-1:0]  arg_arr [NREQ];

    // Unpack the flat per-requester buses
    for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
        assign op_arr[g]  = op[2*g +: 2];
        assign arg_arr[g] = arg[WIDTH*g +: WIDTH];
    end

    // Winner: first requester at or after ptr, wrapping modulo NREQ
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = ptr;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
            cand = (cand == PW'(NREQ - 1)) ? '0 : cand + PW'(1);
        end
    end

    // Handshake FSM: IDLE -> EXEC -> DONE -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            win_reg <= '0;
            lat_op  <= OP_LOAD;
            lat_arg <= '0;
            gnt     <= '0;
            ack     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        win_reg <= win_idx;
                        lat_op  <= op_arr[win_idx];
                        lat_arg <= arg_arr[win_idx];
                        gnt     <= NREQ'(1) << win_idx;
                        busy    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    ack   <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    gnt   <= '0;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    ptr   <= (win_reg == PW'(NREQ - 1)) ? '0 : win_reg + PW'(1);
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Op to J/K translation; bank holds outside EXEC
    always_comb begin
        j = '0;
        k = '0;
        if (state == EXEC) begin
            case (lat_op)
                OP_LOAD: begin
                    j = lat_arg;
                    k = ~lat_arg;
                end
                OP_SET: begin
                    j = lat_arg;
                end
                OP_CLEAR: begin
                    k = lat_arg;
                end
                OP_TOGGLE: begin
                    j = lat_arg;
                    k = lat_arg;
                end
                default: begin
                    j = '0;
                    k = '0;
                end
            endcase
        end
    end

    // JK cell bank: 00 hold, 01 clear, 10 set, 11 toggle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            for (int b = 0; b < int'(WIDTH); b++) begin
                case ({j[b], k[b]})
                    2'b01:   q[b] <= 1'b0;
                    2'b10:   q[b] <= 1'b1;
                    2'b11:   q[b] <= ~q[b];
                    default: q[b] <= q[b];
                endcase
            end
        end
    end

    assign q_bar = ~q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter (WIDTH=8, NREQ=4) with hand-computed expectations.
module tb_jk_bank_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] arg;
    logic [3:0]  gnt;
    logic        ack;
    logic        busy;
    logic [7:0]  q;
    logic [7:0]  q_bar;

    int n_tests;
    int n_fail;

    jk_bank_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .op    (op),
        .arg   (arg),
        .gnt   (gnt),
        .ack   (ack),
        .busy  (busy),
        .q     (q),
        .q_bar (q_bar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [1:0] o, input logic [7:0] a);
        op[2*idx +: 2]  = o;
        arg[8*idx +: 8] = a;
        req[idx]        = 1'b1;
    endtask

    task automatic pulse_reset();
        #3 rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; op = '0; arg = '0;
        #2;
        n_tests++;
        if (q !== 8'h00 || q_bar !== 8'hFF || gnt !== 4'b0 || ack !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: q=%h q_bar=%h gnt=%b ack=%b busy=%b", q, q_bar, gnt, ack, busy);
        end
        tick();
        tick();
        rst = 1'b0;
        set_req(0, 2'b00, 8'h5A);
        tick();
        tick();
        req = '0;
        n_tests++;
        if (q !== 8'h5A || ack !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_preload: q=%h ack=%b expected 5a/1", q, ack);
        end
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if (q !== 8'h00 || q_bar !== 8'hFF || gnt !== 4'b0 || ack !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: q=%h q_bar=%h gnt=%b ack=%b busy=%b", q, q_bar, gnt, ack, busy);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_op();
        logic [1:0] ops  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [7:0] args [4] = '{8'hA5, 8'h0F, 8'hA0, 8'hFF};
        logic [7:0] exps [4] = '{8'hA5, 8'hAF, 8'h0F, 8'hF0};
        for (int s = 0; s < 4; s++) begin
            set_req(1, ops[s], args[s]);
            tick();
            n_tests++;
            if (gnt !== 4'b0010 || ack !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL single_grant[%0d]: gnt=%b ack=%b busy=%b expected 0010/0/1", s, gnt, ack, busy);
            end
            tick();
            n_tests++;
            if (q !== exps[s] || q_bar !== ~exps[s] || ack !== 1'b1 || gnt !== 4'b0010) begin
                n_fail++;
                $display("FAIL single_result[%0d]: q=%h q_bar=%h ack=%b gnt=%b expected q=%h", s, q, q_bar, ack, gnt, exps[s]);
            end
            req = '0;
            tick();
            n_tests++;
            if (ack !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL single_release[%0d]: ack=%b gnt=%b busy=%b", s, ack, gnt, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int last;
        int exp_idx;
        pulse_reset();
        for (int i = 0; i < 4; i++) set_req(i, 2'b00, 8'(8'h10 * (i + 1)));
        cyc  = 0;
        last = 0;
        for (int n = 0; n < 5; n++) begin
            exp_idx = n % 4;
            for (int t = 0; t < 10 && ack !== 1'b1; t++) begin
                tick();
                cyc++;
            end
            n_tests++;
            if (ack !== 1'b1 || gnt !== 4'(1 << exp_idx) || q !== 8'(8'h10 * (exp_idx + 1))) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: ack=%b gnt=%b q=%h expected gnt=%b", n, ack, gnt, q, 4'(1 << exp_idx));
            end
            if (n > 0) begin
                n_tests++;
                if (cyc - last !== 3) begin
                    n_fail++;
                    $display("FAIL rr_spacing[%0d]: %0d cycles expected 3", n, cyc - last);
                end
            end
            last = cyc;
            if (n == 4) req = '0;
            tick();
            cyc++;
        end
        n_tests++;
        if (busy !== 1'b0 || gnt !== 4'b0) begin
            n_fail++;
            $display("FAIL rr_drain: busy=%b gnt=%b", busy, gnt);
        end
    endtask

    task automatic test_wrap();
        set_req(2, 2'b00, 8'h22);
        tick();
        tick();
        req = '0;
        tick();
        set_req(0, 2'b00, 8'h01);
        set_req(2, 2'b00, 8'h04);
        tick();
        n_tests++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_first: gnt=%b expected 0001", gnt);
        end
        tick();
        req[0] = 1'b0;
        n_tests++;
        if (q !== 8'h01 || ack !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_first_q: q=%h ack=%b expected 01/1", q, ack);
        end
        tick();
        tick();
        n_tests++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL wrap_second: gnt=%b expected 0100", gnt);
        end
        tick();
        req = '0;
        n_tests++;
        if (q !== 8'h04 || ack !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_second_q: q=%h ack=%b expected 04/1", q, ack);
        end
        tick();
    endtask

    task automatic test_abort();
        int acks;
        set_req(3, 2'b00, 8'h81);
        tick();
        tick();
        req = '0;
        n_tests++;
        if (q !== 8'h81) begin
            n_fail++;
            $display("FAIL abort_setup: q=%h expected 81", q);
        end
        tick();
        set_req(2, 2'b00, 8'h3C);
        tick();
        n_tests++;
        if (gnt !== 4'b0100 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_grant: gnt=%b busy=%b expected 0100/1", gnt, busy);
        end
        req = '0;
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if (q !== 8'h00 || q_bar !== 8'hFF || gnt !== 4'b0 || ack !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: q=%h q_bar=%h gnt=%b ack=%b busy=%b", q, q_bar, gnt, ack, busy);
        end
        tick();
        rst  = 1'b0;
        acks = 0;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (ack === 1'b1 || q !== 8'h00) acks++;
        end
        n_tests++;
        if (acks !== 0) begin
            n_fail++;
            $display("FAIL abort_no_ack: %0d cycles with ack or changed q, expected 0", acks);
        end
        set_req(2, 2'b00, 8'h3C);
        tick();
        tick();
        req = '0;
        n_tests++;
        if (q !== 8'h3C || ack !== 1'b1 || gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL abort_retry: q=%h ack=%b gnt=%b expected 3c/1/0100", q, ack, gnt);
        end
        tick();
    endtask

    task automatic test_withdrawal();
        set_req(1, 2'b01, 8'hC0);
        tick();
        req = '0;
        op[3:2]   = 2'b10;
        arg[15:8] = 8'hFF;
        tick();
        n_tests++;
        if (q !== 8'hFC || ack !== 1'b1) begin
            n_fail++;
            $display("FAIL withdraw_latched: q=%h ack=%b expected fc/1", q, ack);
        end
        tick();
        n_tests++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL withdraw_release: ack=%b busy=%b expected 0/0", ack, busy);
        end
        set_req(1, 2'b11, 8'h00);
        tick();
        tick();
        req = '0;
        n_tests++;
        if (q !== 8'hFC || ack !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_arg_toggle: q=%h ack=%b expected fc/1", q, ack);
        end
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single_op();
        test_back_to_back();
        test_wrap();
        test_abort();
        test_withdrawal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
